// File: rtl/reg_bank.sv
// reg_bank: four WIDTH-bit registers sharing one combinational read bus, with an
//           external load port, a two-state move tracker, a move counter and a sticky error flag.
// Latency: bus is combinational; register loads, xfer_ack, xfer_count and err update on the next rising clk.
// Backpressure: none; strobes and ext_load are accepted every cycle.
// Ports: clk/reset (sync, active-high); R*_write/R*_read strobes; ext_load/ext_sel/ext_data;
//        bus, R0_q..R3_q, xfer_ack (1-cycle pulse), xfer_count (8-bit, wraps), err (sticky).
module reg_bank #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             R0_write,
   input  logic             R1_write,
   input  logic             R2_write,
   input  logic             R3_write,
   input  logic             R0_read,
   input  logic             R1_read,
   input  logic             R2_read,
   input  logic             R3_read,
   input  logic             ext_load,
   input  logic [1:0]       ext_sel,
   input  logic [WIDTH-1:0] ext_data,
   output logic [WIDTH-1:0] bus,
   output logic [WIDTH-1:0] R0_q,
   output logic [WIDTH-1:0] R1_q,
   output logic [WIDTH-1:0] R2_q,
   output logic [WIDTH-1:0] R3_q,
   output logic             xfer_ack,
   output logic [7:0]       xfer_count,
   output logic             err
);

   localparam logic [0:0] IDLE   = 1'b0;
   localparam logic [0:0] ACTIVE = 1'b1;

   logic [3:0]       wr;
   logic [3:0]       rd;
   logic [WIDTH-1:0] regs [4];
   logic [0:0]       state;
   logic             multi_read;
   logic             one_read;
   logic             any_strobe;
   logic             err_set;

   assign wr = {R3_write, R2_write, R1_write, R0_write};
   assign rd = {R3_read, R2_read, R1_read, R0_read};

   // Clearing the lowest set bit leaves something only if two or more reads are high.
   assign multi_read = ((rd & (rd - 4'd1)) != 4'd0);
   assign one_read   = (rd != 4'd0) && !multi_read;
   assign any_strobe = (wr != 4'd0) || (rd != 4'd0);

   assign err_set = multi_read
                  || ((wr != 4'd0) && (rd == 4'd0))
                  || (ext_load && (state == ACTIVE));

   assign R0_q = regs[0];
   assign R1_q = regs[1];
   assign R2_q = regs[2];
   assign R3_q = regs[3];

   // Conflicting or absent reads leave the bus at zero, so writers then load zero.
   always_comb begin
      bus = '0;
      if (one_read) begin
         case (rd)
            4'b0001: bus = regs[0];
            4'b0010: bus = regs[1];
            4'b0100: bus = regs[2];
            4'b1000: bus = regs[3];
            default: bus = '0;
         endcase
      end
   end

   // ext_load takes priority and blocks every strobe-driven write in the same cycle.
   // A self-move (read and write on one register) reloads that register from the bus, i.e. itself.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) regs[i] <= '0;
      end else if (ext_load) begin
         regs[ext_sel] <= ext_data;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (wr[i]) regs[i] <= bus;
         end
      end
   end

   // A move is any run of cycles with strobes high; it completes on the first all-low cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         xfer_ack   <= 1'b0;
         xfer_count <= 8'd0;
      end else begin
         xfer_ack <= 1'b0;
         case (state)
            IDLE: begin
               if (any_strobe) state <= ACTIVE;
            end
            ACTIVE: begin
               if (!any_strobe) begin
                  state      <= IDLE;
                  xfer_ack   <= 1'b1;
                  xfer_count <= xfer_count + 8'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset)        err <= 1'b0;
      else if (err_set) err <= 1'b1;
   end

endmodule

// File: doc/reg_bank.md
REG_BANK -- requirements
Module: reg_bank

Interface
REQ-001 The module SHALL have parameter WIDTH, default 16, meaning data width of each register and of the bus.
REQ-002 The module SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 The module SHALL have port reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 The module SHALL have ports R0_write..R3_write  input  1 each  per-register write strobe; high means load from bus.
REQ-005 The module SHALL have ports R0_read..R3_read  input  1 each  per-register read strobe; high means drive register onto bus.
REQ-006 The module SHALL have port ext_load  input  1  external load request.
REQ-007 The module SHALL have port ext_sel  input  2  target register for ext_load.
REQ-008 The module SHALL have port ext_data  input  WIDTH  value for ext_load.
REQ-009 The module SHALL have port bus  output  WIDTH  combinational read bus.
REQ-010 The module SHALL have ports R0_q..R3_q  output  WIDTH each  current register contents.
REQ-011 The module SHALL have port xfer_ack  output  1  one-cycle pulse at completion of a move.
REQ-012 The module SHALL have port xfer_count  output  8  count of completed moves.
REQ-013 The module SHALL have port err  output  1  sticky protocol error flag.

Function
REQ-014 bus SHALL equal the register whose read strobe is high when exactly one read strobe is high, else 0.
REQ-015 On a rising clk with no ext_load, every register whose write strobe is high SHALL load bus; the others SHALL hold.
REQ-016 A register with read and write both high (self-move) SHALL reload its own value, leaving it unchanged.
REQ-017 ext_load high SHALL load ext_data into register ext_sel and SHALL suppress all strobe-driven writes that cycle.
REQ-018 The module SHALL implement a two-state FSM: IDLE and ACTIVE.
REQ-019 In IDLE, any read or write strobe high SHALL move the FSM to ACTIVE on the next edge.
REQ-020 In ACTIVE, all strobes low SHALL return the FSM to IDLE, pulse xfer_ack for exactly that following cycle, and increment xfer_count.
REQ-021 In ACTIVE, any strobe still high SHALL keep the FSM in ACTIVE.
REQ-022 xfer_ack SHALL be registered, giving one cycle of latency after the strobes drop.
REQ-023 xfer_count SHALL wrap from 255 to 0.
REQ-024 err SHALL be set on the next edge when two or more read strobes are high together.
REQ-025 err SHALL be set on the next edge when any write strobe is high with no read strobe high.
REQ-026 err SHALL be set on the next edge when ext_load is high while the FSM is ACTIVE; the ext_load write still takes effect.
REQ-027 err SHALL remain set until reset.
REQ-028 A move with an err condition SHALL still complete the FSM cycle and still count.

Reset
REQ-029 While reset is high at a rising edge, R0_q..R3_q, xfer_count and err SHALL clear to 0, xfer_ack SHALL clear to 0, and the FSM SHALL enter IDLE.
REQ-030 Reset SHALL override ext_load and all strobes that cycle.
REQ-031 Reset asserted in ACTIVE SHALL abort the move: no xfer_ack and no count increment.
REQ-032 Before the first clk edge with reset high, all outputs SHALL be treated as unknown.

Verification
REQ-033 Ext-load and move: ext_load R2=0x00A5, then R1_write+R2_read for 1 cycle, then strobes low -> R1_q=0x00A5, xfer_ack pulses 1 cycle, xfer_count=1, err=0.
REQ-034 Ext-load priority: ext_load R0=0x1234 while R0_write+R3_read are high -> R0_q=0x1234, err=0 if FSM IDLE at that edge.
REQ-035 Read conflict: R0_read+R1_read+R2_write are high -> bus=0, R2_q=0, err=1, and err stays 1 over 10 further idle cycles.
REQ-036 Counter wrap: 256 legal moves -> xfer_count returns to 0 and xfer_ack pulses 256 times.
REQ-037 Reset mid-move: strobes high, reset during ACTIVE -> all registers 0, FSM IDLE, xfer_ack never pulses, xfer_count=0.
REQ-038 Self-move: R3=0x0F0F, R3_read+R3_write for 1 cycle -> R3_q=0x0F0F, xfer_count increments by 1.
